mul_unit: RTL and testbench

- Iterative shift-add multiplier for MUL/MLA, directly downstream of the register file.
- Takes rd1 (Rm), rd2 (Rs) and the accumulate operand (Rn, read through the rsa/rsd port) at issue.
- Produces the low 32 bits of the product plus N/Z flags.
- Returns the destination register tag so the result writes back through wd3/wa3/we3 on completion; the control unit stalls the PC while busy is high.

---
 rtl/mul_if.sv | 28 ++
 rtl/mul_unit.sv | 129 ++++++++++++
 tb/tb_mul_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_if.sv
// Issue/completion bundle between the control path and the iterative multiplier.
// master drives the operands and start; slave (the multiplier) returns the result and flags.
interface mul_if;
  logic        start;
  logic        acc_en;
  logic        set_flags;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] acc_in;
  logic [3:0]  wa_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  wa_out;
  logic        flags_we;
  logic        n_flag;
  logic        z_flag;

  modport master (
    output start, acc_en, set_flags, a_in, b_in, acc_in, wa_in,
    input  busy, done, result, wa_out, flags_we, n_flag, z_flag
  );

  modport slave (
    input  start, acc_en, set_flags, a_in, b_in, acc_in, wa_in,
    output busy, done, result, wa_out, flags_we, n_flag, z_flag
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add MUL/MLA unit retiring BITS_PER_CYCLE multiplier bits per RUN cycle.
// Define MUL_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are zero.
module mul_unit #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic clk,
  input  logic reset_n,
  mul_if.slave bus
);

  localparam int         ITER     = 32 / BITS_PER_CYCLE;
  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg;
  logic [31:0] mcand_reg;
  logic [31:0] mplier_reg;
  logic [31:0] acc_reg;
  logic [5:0]  cnt_reg;
  logic        set_flags_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        flags_we_reg;
  logic [31:0] result_reg;
  logic [3:0]  wa_out_reg;
  logic        n_flag_reg;
  logic        z_flag_reg;

  logic [31:0] pp_terms [BITS_PER_CYCLE];
  logic [31:0] pp_sum;
  logic [31:0] acc_next;
  logic [31:0] mplier_next;
  logic        last_iter;

  // One shifted copy of the multiplicand per retired multiplier bit.
  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
      assign pp_terms[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 32'd0;
    end
  endgenerate

  always_comb begin
    pp_sum = 32'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      pp_sum = pp_sum + pp_terms[i];
    end
  end

  assign acc_next    = acc_reg + pp_sum;
  assign mplier_next = mplier_reg >> BITS_PER_CYCLE;

`ifdef MUL_EARLY_TERM_EN
  assign last_iter = (cnt_reg == LAST_CNT) || (mplier_next == 32'd0);
`else
  assign last_iter = (cnt_reg == LAST_CNT);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      mcand_reg     <= 32'd0;
      mplier_reg    <= 32'd0;
      acc_reg       <= 32'd0;
      cnt_reg       <= 6'd0;
      set_flags_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      flags_we_reg  <= 1'b0;
      result_reg    <= 32'd0;
      wa_out_reg    <= 4'd0;
      n_flag_reg    <= 1'b0;
      z_flag_reg    <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg     <= 1'b0;
          flags_we_reg <= 1'b0;
          if (bus.start) begin
            mcand_reg     <= bus.a_in;
            mplier_reg    <= bus.b_in;
            acc_reg       <= bus.acc_en ? bus.acc_in : 32'd0;
            cnt_reg       <= 6'd0;
            wa_out_reg    <= bus.wa_in;
            set_flags_reg <= bus.set_flags;
            busy_reg      <= 1'b1;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
          mplier_reg <= mplier_next;
          cnt_reg    <= cnt_reg + 6'd1;
          if (last_iter) begin
            // Visible outputs only change here, so they hold through IDLE.
            result_reg   <= acc_next;
            n_flag_reg   <= acc_next[31];
            z_flag_reg   <= (acc_next == 32'd0);
            done_reg     <= 1'b1;
            flags_we_reg <= set_flags_reg;
            state_reg    <= DONE;
          end
        end
        DONE: begin
          done_reg     <= 1'b0;
          flags_we_reg <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.result   = result_reg;
  assign bus.wa_out   = wa_out_reg;
  assign bus.flags_we = flags_we_reg;
  assign bus.n_flag   = n_flag_reg;
  assign bus.z_flag   = z_flag_reg;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: a BITS_PER_CYCLE=1 instance and a BITS_PER_CYCLE=4 instance.
// Expected latencies follow MUL_EARLY_TERM_EN when the bench is built with it.
module tb_mul_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mul_if if0 ();
  mul_if if4 ();

  mul_unit #(.BITS_PER_CYCLE(1)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  mul_unit #(.BITS_PER_CYCLE(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4));

  typedef struct {
    logic [31:0] res;
    logic [3:0]  wa;
    logic        fwe;
    int          start;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q4[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycles from the start cycle to the done cycle inclusive of the DONE cycle.
  function automatic int exp_lat(input logic [31:0] b, input int bpc);
    int run;
    int msb;
    run = 32 / bpc;
`ifdef MUL_EARLY_TERM_EN
    msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    run = (msb < 0) ? 1 : (msb + bpc) / bpc;
`else
    msb = 0;
`endif
    return run + msb - msb + 1;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (if0.flags_we === 1'b1 && if0.done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL u0_flags_we_without_done: got 1 expected 0");
    end
    if (if0.done === 1'b1) begin
      done_cnt0++;
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = q0.pop_front();
        $display("u0 done: result=%h wa=%h n=%b z=%b fwe=%b lat=%0d", if0.result, if0.wa_out,
                 if0.n_flag, if0.z_flag, if0.flags_we, cyc - e.start + 1);
        chk("u0_result", if0.result, e.res);
        chk("u0_wa_out", 32'(if0.wa_out), 32'(e.wa));
        chk("u0_n_flag", 32'(if0.n_flag), 32'(e.res[31]));
        chk("u0_z_flag", 32'(if0.z_flag), 32'(e.res == 32'd0));
        chk("u0_flags_we", 32'(if0.flags_we), 32'(e.fwe));
        chk("u0_latency", 32'(cyc - e.start + 1), 32'(e.lat));
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (if4.done === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL u4_unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = q4.pop_front();
        $display("u4 done: result=%h wa=%h lat=%0d", if4.result, if4.wa_out, cyc - e.start + 1);
        chk("u4_result", if4.result, e.res);
        chk("u4_wa_out", 32'(if4.wa_out), 32'(e.wa));
        chk("u4_latency", 32'(cyc - e.start + 1), 32'(e.lat));
      end
    end
  end

  task automatic issue(input bit four, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] acc, input logic en, input logic sf,
                       input logic [3:0] wa, input logic [31:0] exp_res);
    exp_t e;
    @(negedge clk);
    if (four) begin
      if4.a_in = a; if4.b_in = b; if4.acc_in = acc; if4.acc_en = en;
      if4.set_flags = sf; if4.wa_in = wa; if4.start = 1'b1;
    end else begin
      if0.a_in = a; if0.b_in = b; if0.acc_in = acc; if0.acc_en = en;
      if0.set_flags = sf; if0.wa_in = wa; if0.start = 1'b1;
    end
    @(posedge clk);
    #1;
    e.res = exp_res; e.wa = wa; e.fwe = sf; e.start = cyc;
    e.lat = exp_lat(b, four ? 4 : 1);
    if (four) q4.push_back(e);
    else q0.push_back(e);
    @(negedge clk);
    if0.start = 1'b0;
    if4.start = 1'b0;
  endtask

  task automatic wait_idle(input bit four);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (four ? (q4.size() == 0 && !if4.busy) : (q0.size() == 0 && !if0.busy)) return;
    end
    checks++; errors++;
    $display("FAIL %s_timeout: got busy after 100 cycles expected idle", four ? "u4" : "u0");
  endtask

  typedef struct {
    logic [31:0] a, b, acc;
    logic        en, sf;
    logic [3:0]  wa;
    logic [31:0] res;
  } vec_t;

  vec_t v0[7] = '{
    '{32'h0000_1234, 32'h0000_0010, 32'd0, 1'b0, 1'b0, 4'd3,   32'h0001_2340},
    '{32'hFFFF_FFFF, 32'd2,         32'd1, 1'b1, 1'b1, 4'd5,   32'hFFFF_FFFF},
    '{32'hFFFF_FFFF, 32'd2,         32'd2, 1'b1, 1'b1, 4'd6,   32'h0000_0000},
    '{32'd100,       32'd3,         32'd7, 1'b0, 1'b0, 4'd1,   32'd300},
    '{32'h0000_0055, 32'd0,         32'd0, 1'b0, 1'b1, 4'd2,   32'd0},
    '{32'd3,         32'h8000_0000, 32'd0, 1'b0, 1'b0, 4'd9,   32'h8000_0000},
    '{32'hFFFF_FFFE, 32'd3,         32'd10, 1'b1, 1'b1, 4'hF,  32'd4}
  };

  vec_t v4[2] = '{
    '{32'h8000_0001, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 4'd7,   32'h7FFF_FFFF},
    '{32'h1234_5678, 32'h0000_0010, 32'd0, 1'b0, 1'b0, 4'd8,   32'h2345_6780}
  };

  initial begin
    int dseen;
    int k;
    if0.start = 0; if0.acc_en = 0; if0.set_flags = 0; if0.a_in = 0; if0.b_in = 0;
    if0.acc_in = 0; if0.wa_in = 0;
    if4.start = 0; if4.acc_en = 0; if4.set_flags = 0; if4.a_in = 0; if4.b_in = 0;
    if4.acc_in = 0; if4.wa_in = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_done", 32'(if0.done), 32'd0);
    chk("rst_flags_we", 32'(if0.flags_we), 32'd0);
    chk("rst_result", if0.result, 32'd0);
    chk("rst_wa_out", 32'(if0.wa_out), 32'd0);
    chk("rst_n_flag", 32'(if0.n_flag), 32'd0);
    chk("rst_z_flag", 32'(if0.z_flag), 32'd1);
    chk("rst_u4_z_flag", 32'(if4.z_flag), 32'd1);
    reset_n = 1'b1;

    foreach (v0[i]) begin
      issue(1'b0, v0[i].a, v0[i].b, v0[i].acc, v0[i].en, v0[i].sf, v0[i].wa, v0[i].res);
      wait_idle(1'b0);
    end
    foreach (v4[i]) begin
      issue(1'b1, v4[i].a, v4[i].b, v4[i].acc, v4[i].en, v4[i].sf, v4[i].wa, v4[i].res);
      wait_idle(1'b1);
    end

    // Starts during RUN and DONE must be dropped.
    issue(1'b0, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 4'd4, 32'd42);
    repeat (4) @(negedge clk);
    if0.a_in = 32'd5; if0.b_in = 32'd5; if0.wa_in = 4'd11; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    k = 0;
    while (if0.done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("busy_test_done_seen", 32'(if0.done), 32'd1);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    chk("start_in_done_ignored_busy", 32'(if0.busy), 32'd0);
    chk("start_in_done_result_held", if0.result, 32'd42);
    @(negedge clk);
    if0.start = 1'b0;
    chk("result_held_idle", if0.result, 32'd42);
    issue(1'b0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 4'd11, 32'd25);
    wait_idle(1'b0);

    // Abandon an operation mid-RUN with reset.
    @(negedge clk);
    if0.a_in = 32'd7; if0.b_in = 32'd9; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrun_rst_busy", 32'(if0.busy), 32'd0);
    chk("midrun_rst_result", if0.result, 32'd0);
    chk("midrun_rst_z_flag", 32'(if0.z_flag), 32'd1);
    chk("midrun_rst_done", 32'(if0.done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dseen = done_cnt0;
    repeat (40) @(negedge clk);
    chk("no_done_after_reset", 32'(done_cnt0 - dseen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
